// File: rtl/i2s_playback_serializer_if.sv
// Source-side handshake for the I2S playback serializer: one stereo PCM pair per transfer.
interface i2s_playback_serializer_if #(
    parameter int unsigned SAMPLE_BITS = 16
) ();
    logic                   s_valid;
    logic                   s_ready;
    logic [SAMPLE_BITS-1:0] s_left;
    logic [SAMPLE_BITS-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/i2s_playback_serializer.sv
// Stereo I2S playback serializer: FIFO-buffered PCM pairs out on bclk/pblrc/pbdat.
// Define I2S_TX_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module i2s_playback_serializer #(
    parameter int unsigned SAMPLE_BITS   = 16,
    parameter int unsigned SLOT_BITS     = 32,
    parameter int unsigned MCLK_PER_BCLK = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    i2s_playback_serializer_if.slave          src,
    output logic                              bclk,
    output logic                              pblrc,
    output logic                              pbdat,
    output logic                              frame_start,
    output logic                              underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                       underrun_count
`endif
);

    localparam int unsigned PHASE_W = $clog2(MCLK_PER_BCLK);
    localparam int unsigned SLOT_W  = $clog2(SLOT_BITS);
    localparam int unsigned CNT_W   = PHASE_W + SLOT_W + 1;
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0]  left_q, left_d;
    logic [SAMPLE_BITS-1:0]  right_q, right_d;
    logic                    pbdat_q, pbdat_d;
    logic                    frame_start_q, underrun_q, underrun_d;
    logic [SLOT_W-1:0]       slot_c;
    logic                    bit_edge;
    logic                    in_data;
    logic                    load;

    logic [2*SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [2*SAMPLE_BITS-1:0] head;
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     full_q, full_d;
    logic                     push, pop;

    // Frame load happens on the edge where the counter wraps to zero.
    assign load = (cnt_q == '1);
    assign push = src.s_valid & ~full_q;
    assign pop  = load & (level_q != '0);
    assign head = mem_q[rd_ptr_q];

    assign src.s_ready  = ~full_q;
    assign bclk         = cnt_q[PHASE_W-1];
    assign pblrc        = cnt_q[CNT_W-1];
    assign pbdat        = pbdat_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign fifo_level   = level_q;

    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        slot_c     = cnt_d[PHASE_W +: SLOT_W];
        bit_edge   = (cnt_d[PHASE_W-1:0] == '0);
        in_data    = (slot_c != '0) && (slot_c <= SLOT_W'(SAMPLE_BITS));
        pbdat_d    = pbdat_q;
        left_d     = left_q;
        right_d    = right_q;
        underrun_d = load & (level_q == '0);

        // Slot 0 is the I2S one-bclk delay; the MSB goes out in slot 1.
        if (bit_edge) begin
            pbdat_d = 1'b0;
            if (in_data) begin
                if (cnt_d[CNT_W-1]) begin
                    pbdat_d = right_q[SAMPLE_BITS-1];
                    right_d = right_q << 1;
                end else begin
                    pbdat_d = left_q[SAMPLE_BITS-1];
                    left_d  = left_q << 1;
                end
            end
        end

        // An empty FIFO plays silence rather than repeating the last pair.
        if (load) begin
            left_d  = pop ? head[2*SAMPLE_BITS-1:SAMPLE_BITS] : '0;
            right_d = pop ? head[SAMPLE_BITS-1:0] : '0;
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d = (level_d == LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            left_q        <= '0;
            right_q       <= '0;
            pbdat_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            full_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            right_q       <= right_d;
            pbdat_q       <= pbdat_d;
            frame_start_q <= load;
            underrun_q    <= underrun_d;
            level_q       <= level_d;
            full_q        <= full_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {src.s_left, src.s_right};
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_count_q <= '0;
        end else if (underrun_d && (underrun_count_q != 16'hFFFF)) begin
            underrun_count_q <= underrun_count_q + 16'd1;
        end
    end

    assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_i2s_playback_serializer.sv
// Directed bench for i2s_playback_serializer at default parameters.
// Covers I2S_TX_UNDERRUN_CNT_EN when the macro is defined for the build.
module tb_i2s_playback_serializer;

    logic       clk;
    logic       rst;
    logic       bclk, pblrc, pbdat, frame_start, underrun;
    logic [2:0] fifo_level;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    int         vectors;
    int         miscompares;
    int         adv_under;
    logic [7:0] tcnt;

    i2s_playback_serializer_if #(.SAMPLE_BITS(16)) src_if ();

    i2s_playback_serializer dut (
        .clk         (clk),
        .rst         (rst),
        .src         (src_if),
        .bclk        (bclk),
        .pblrc       (pblrc),
        .pbdat       (pbdat),
        .frame_start (frame_start),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference frame position: 256 clk per frame, zero while reset is held.
    always @(posedge clk or posedge rst) begin
        if (rst) tcnt <= 8'd0;
        else     tcnt <= tcnt + 8'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (underrun) adv_under++;
    endtask

    task automatic advance_to(input logic [7:0] target);
        int guard;
        guard = 0;
        while (tcnt != target && guard < 600) begin
            step();
            guard++;
        end
        if (guard >= 600) begin
            miscompares++;
            $error("FAIL advance_timeout: observed %0d expected %0d", tcnt, target);
        end
    endtask

    // Samples one frame from cnt=0: pbdat at the start and end of each slot.
    task automatic capture(output logic [63:0] w_a, output logic [63:0] w_b,
                           output int n_under, output int n_bad);
        n_under = 0;
        n_bad   = 0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] k;
            int         idx;
            k   = tcnt;
            idx = 63 - int'(k[7:2]);
            if (bclk !== k[1] || pblrc !== k[7] || frame_start !== (k == 8'd0)) n_bad++;
            if (underrun) n_under++;
            if (k[1:0] == 2'd0) w_a[idx] = pbdat;
            if (k[1:0] == 2'd3) w_b[idx] = pbdat;
            @(negedge clk);
        end
    endtask

    task automatic frame_check(input string tag, input logic [15:0] l, input logic [15:0] r,
                               input int exp_under);
        logic [63:0] w_a, w_b, exp;
        int          n_under, n_bad;
        exp = {1'b0, l, 15'b0, 1'b0, r, 15'b0};
        capture(w_a, w_b, n_under, n_bad);
        check({tag, "_bits_early"}, w_a, exp);
        check({tag, "_bits_late"}, w_b, exp);
        check({tag, "_underruns"}, 64'(n_under), 64'(exp_under));
        check({tag, "_timing_errs"}, 64'(n_bad), 64'd0);
    endtask

    task automatic push_hold(input logic [15:0] l, input logic [15:0] r);
        src_if.s_valid = 1'b1;
        src_if.s_left  = l;
        src_if.s_right = r;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        adv_under      = 0;
        rst            = 1'b1;
        src_if.s_valid = 1'b0;
        src_if.s_left  = '0;
        src_if.s_right = '0;
        repeat (3) @(negedge clk);
        check("rst_bclk", 64'(bclk), 64'd0);
        check("rst_pbdat", 64'(pbdat), 64'd0);
        check("rst_ready", 64'(src_if.s_ready), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;

        // One pair, then one full frame of bits
        push_hold(16'hA5A5, 16'h0001);
        step();
        src_if.s_valid = 1'b0;
        check("push1_level", 64'(fifo_level), 64'd1);
        adv_under = 0;
        advance_to(8'd255);
        check("first_frame_no_underrun", 64'(adv_under), 64'd0);
        step();
        check("wrap_frame_start", 64'(frame_start), 64'd1);
        check("wrap_underrun", 64'(underrun), 64'd0);
        check("wrap_level", 64'(fifo_level), 64'd0);
        frame_check("a5a5", 16'hA5A5, 16'h0001, 0);

        // Reset mid-frame while the right MSB is on the wire
        push_hold(16'h8000, 16'hFFFF);
        step();
        src_if.s_valid = 1'b0;
        advance_to(8'd0);
        advance_to(8'd10);
        push_hold(16'h0000, 16'h0000);
        step();
        src_if.s_valid = 1'b0;
        advance_to(8'd134);
        check("pre_rst_pbdat", 64'(pbdat), 64'd1);
        check("pre_rst_pblrc", 64'(pblrc), 64'd1);
        check("pre_rst_level", 64'(fifo_level), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_bclk", 64'(bclk), 64'd0);
        check("midrst_pblrc", 64'(pblrc), 64'd0);
        check("midrst_pbdat", 64'(pbdat), 64'd0);
        check("midrst_ready", 64'(src_if.s_ready), 64'd1);
        check("midrst_level", 64'(fifo_level), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fill the FIFO, hold a fifth pair until the next load frees a slot
        push_hold(16'h1111, 16'h2222);
        step();
        push_hold(16'h3333, 16'h4444);
        step();
        push_hold(16'h8001, 16'h7FFE);
        step();
        push_hold(16'hFFFF, 16'h0000);
        step();
        push_hold(16'h5555, 16'hAAAA);
        check("full_level", 64'(fifo_level), 64'd4);
        check("full_ready", 64'(src_if.s_ready), 64'd0);
        advance_to(8'd255);
        check("full_hold_ready", 64'(src_if.s_ready), 64'd0);
        check("full_hold_level", 64'(fifo_level), 64'd4);
        step();
        check("after_load_level", 64'(fifo_level), 64'd3);
        check("after_load_ready", 64'(src_if.s_ready), 64'd1);
        step();
        src_if.s_valid = 1'b0;
        check("fifth_level", 64'(fifo_level), 64'd4);
        check("fifth_ready", 64'(src_if.s_ready), 64'd0);
        advance_to(8'd0);
        frame_check("q1", 16'h3333, 16'h4444, 0);
        frame_check("q2", 16'h8001, 16'h7FFE, 0);
        frame_check("q3", 16'hFFFF, 16'h0000, 0);
        frame_check("q5", 16'h5555, 16'hAAAA, 0);

        // Three idle frames
        frame_check("idle1", 16'h0000, 16'h0000, 1);
        frame_check("idle2", 16'h0000, 16'h0000, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        check("ucnt_3", 64'(underrun_count), 64'd3);
`endif
        frame_check("idle3", 16'h0000, 16'h0000, 1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
        advance_to(8'd255);
        force dut.underrun_count_q = 16'hFFFE;
        #1;
        release dut.underrun_count_q;
        step();
        check("ucnt_ffff", 64'(underrun_count), 64'hFFFF);
        advance_to(8'd255);
        step();
        check("ucnt_sat", 64'(underrun_count), 64'hFFFF);
`endif

        // Push lands exactly on the load edge of an empty FIFO
        advance_to(8'd255);
        push_hold(16'hC3C3, 16'h0F0F);
        step();
        src_if.s_valid = 1'b0;
        check("edge_push_underrun", 64'(underrun), 64'd1);
        check("edge_push_level", 64'(fifo_level), 64'd1);
        frame_check("edge_silent", 16'h0000, 16'h0000, 1);
        check("edge_next_level", 64'(fifo_level), 64'd0);
        frame_check("edge_play", 16'hC3C3, 16'h0F0F, 0);

        // Reset at cnt=100 with two pairs queued
        push_hold(16'h1234, 16'h5678);
        step();
        push_hold(16'h9ABC, 16'hDEF0);
        step();
        src_if.s_valid = 1'b0;
        advance_to(8'd100);
        check("flush_pre_level", 64'(fifo_level), 64'd2);
        rst = 1'b1;
        #1;
        check("flush_level", 64'(fifo_level), 64'd0);
        check("flush_ready", 64'(src_if.s_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        adv_under = 0;
        advance_to(8'd255);
        check("flush_no_early_underrun", 64'(adv_under), 64'd0);
        step();
        check("flush_wrap_underrun", 64'(underrun), 64'd1);
        frame_check("flush_f1", 16'h0000, 16'h0000, 1);
        frame_check("flush_f2", 16'h0000, 16'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
